// File: rtl/rc4_stream_cipher.sv
// RC4 engine: loadable key, KSA, then PRGA keystream XORed onto a valid/ready byte stream.
// Optional post-KSA keystream discard enabled by defining RC4_DROP_EN (DROP_N bytes).
module rc4_stream_cipher #(
   parameter int KEY_MAX = 16,
   parameter int KLW     = $clog2(KEY_MAX + 1),
   parameter int KAW     = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1,
   parameter int DROP_N  = 256
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           key_wr,
   input  logic [KAW-1:0] key_addr,
   input  logic [7:0]     key_data,
   input  logic [KLW-1:0] key_len,
   input  logic           start,
   output logic           busy,
   output logic           init_done,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [7:0]     in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [7:0]     out_data
);

   typedef enum logic [2:0] {
      IDLE, INIT, KSA, READY
`ifdef RC4_DROP_EN
      , DROP
`endif
   } state_t;

`ifdef RC4_DROP_EN
   localparam int DW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
   logic [DW-1:0]  drop_q;
`endif

   state_t         state_q;
   logic [7:0]     i_q, j_q;
   logic [KLW-1:0] k_q, klen_q;
   logic           out_valid_q;
   logic [7:0]     out_data_q;

   logic [7:0]     s_q   [256];
   logic [7:0]     key_q [KEY_MAX];

   logic [KAW-1:0] kidx_d;
   logic [7:0]     ksa_jn_d;
   logic [7:0]     pr_i_d, pr_j_d, pr_si_d, pr_sj_d, pr_t_d, ks_d;
   logic           start_ok_d, key_ok_d, xfer_d, step_d;
   logic [KLW-1:0] klen_d, k_inc_d;

   always_comb begin
      kidx_d   = k_q[KAW-1:0];
      ksa_jn_d = j_q + s_q[i_q] + key_q[kidx_d];
      k_inc_d  = k_q + 1'b1;
      pr_i_d   = i_q + 8'd1;
      pr_si_d  = s_q[pr_i_d];
      pr_j_d   = j_q + pr_si_d;
      pr_sj_d  = s_q[pr_j_d];
      pr_t_d   = pr_si_d + pr_sj_d;
      // keystream reads the post-swap array: patch the two swapped slots
      if (pr_t_d == pr_i_d)      ks_d = pr_sj_d;
      else if (pr_t_d == pr_j_d) ks_d = pr_si_d;
      else                       ks_d = s_q[pr_t_d];

      in_ready   = (state_q == READY) && (!out_valid_q || out_ready);
      xfer_d     = in_valid && in_ready;
      start_ok_d = start && ((state_q == IDLE) || (state_q == READY));
      key_ok_d   = key_wr && ((state_q == IDLE) || (state_q == READY)) &&
                   ({1'b0, key_addr} < (KAW + 1)'(KEY_MAX));
      if ((key_len == '0) || (int'(key_len) > KEY_MAX)) klen_d = KLW'(KEY_MAX);
      else                                               klen_d = key_len;
`ifdef RC4_DROP_EN
      step_d = xfer_d || (state_q == DROP);
`else
      step_d = xfer_d;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         i_q         <= '0;
         j_q         <= '0;
         k_q         <= '0;
         klen_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef RC4_DROP_EN
         drop_q      <= '0;
`endif
      end else if (start_ok_d) begin
         klen_q      <= klen_d;
         out_valid_q <= 1'b0;
         state_q     <= INIT;
      end else begin
         case (state_q)
            INIT: begin
               i_q     <= '0;
               j_q     <= '0;
               k_q     <= '0;
               state_q <= KSA;
            end
            KSA: begin
               j_q <= ksa_jn_d;
               i_q <= i_q + 8'd1;
               k_q <= (k_inc_d == klen_q) ? '0 : k_inc_d;
               if (i_q == 8'd255) begin
                  i_q <= '0;
                  j_q <= '0;
`ifdef RC4_DROP_EN
                  drop_q  <= '0;
                  state_q <= (DROP_N == 0) ? READY : DROP;
`else
                  state_q <= READY;
`endif
               end
            end
`ifdef RC4_DROP_EN
            DROP: begin
               i_q <= pr_i_d;
               j_q <= pr_j_d;
               if (int'(drop_q) == DROP_N - 1) state_q <= READY;
               else                            drop_q  <= DW'(drop_q + 1'b1);
            end
`endif
            READY: begin
               if (xfer_d) begin
                  i_q         <= pr_i_d;
                  j_q         <= pr_j_d;
                  out_data_q  <= in_data ^ ks_d;
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // S and the key buffer are plain storage with no reset
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         for (int n = 0; n < 256; n++) s_q[n] <= 8'(n);
      end else if (state_q == KSA) begin
         s_q[i_q]      <= s_q[ksa_jn_d];
         s_q[ksa_jn_d] <= s_q[i_q];
      end else if (step_d) begin
         s_q[pr_i_d] <= pr_sj_d;
         s_q[pr_j_d] <= pr_si_d;
      end
      if (key_ok_d) key_q[key_addr] <= key_data;
   end

`ifdef RC4_DROP_EN
   assign busy = (state_q == INIT) || (state_q == KSA) || (state_q == DROP);
`else
   assign busy = (state_q == INIT) || (state_q == KSA);
`endif
   assign init_done = (state_q == READY);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Randomised bench for rc4_stream_cipher against a plain-array RC4 reference model.
module tb_rc4_stream_cipher;
   localparam int KEY_MAX = 16;
   localparam int KLW     = $clog2(KEY_MAX + 1);
   localparam int KAW     = $clog2(KEY_MAX);
   localparam int DROP_N  = 256;
`ifdef RC4_DROP_EN
   localparam int INIT_LAT = 257 + DROP_N;
   localparam bit KV_OK    = 1'b0;
`else
   localparam int INIT_LAT = 257;
   localparam bit KV_OK    = 1'b1;
`endif

   logic           clk = 1'b0, rst = 1'b1;
   logic           key_wr = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [KAW-1:0] key_addr = '0;
   logic [7:0]     key_data = '0, in_data = '0;
   logic [KLW-1:0] key_len = '0;
   logic           busy, init_done, in_ready, out_valid;
   logic [7:0]     out_data;

   rc4_stream_cipher #(.KEY_MAX(KEY_MAX), .DROP_N(DROP_N)) dut (
      .clk(clk), .rst(rst), .key_wr(key_wr), .key_addr(key_addr), .key_data(key_data),
      .key_len(key_len), .start(start), .busy(busy), .init_done(init_done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: textbook RC4 on plain arrays
   logic [7:0] mS [256];
   logic [7:0] mkey [KEY_MAX];
   int mi, mj;

   function automatic logic [7:0] m_next();
      logic [7:0] t;
      mi = (mi + 1) % 256;
      mj = (mj + mS[mi]) % 256;
      t = mS[mi]; mS[mi] = mS[mj]; mS[mj] = t;
      return mS[(mS[mi] + mS[mj]) % 256];
   endfunction

   task automatic m_init(input int len);
      logic [7:0] t;
      int j = 0;
      for (int n = 0; n < 256; n++) mS[n] = 8'(n);
      for (int n = 0; n < 256; n++) begin
         j = (j + mS[n] + mkey[n % len]) % 256;
         t = mS[n]; mS[n] = mS[j]; mS[j] = t;
      end
      mi = 0; mj = 0;
`ifdef RC4_DROP_EN
      for (int n = 0; n < DROP_N; n++) void'(m_next());
`endif
   endtask

   task automatic load_key(input logic [7:0] k[$]);
      foreach (k[n]) begin
         key_wr = 1'b1; key_addr = KAW'(n); key_data = k[n];
         mkey[n] = k[n];
         @(posedge clk); #1;
      end
      key_wr = 1'b0;
   endtask

   task automatic do_start(input string tag, input int len, input int poke);
      int cnt = 0;
      bit bad = 1'b0;
      start = 1'b1; key_len = KLW'(len);
      @(posedge clk); #1;
      start = 1'b0; key_len = '0;
      chk({tag, "_ovclr"}, out_valid, 0);
      while (!init_done && cnt < 3000) begin
         if (!busy || in_ready || out_valid) bad = 1'b1;
         start = (cnt == poke); key_wr = (cnt == poke);
         key_addr = '0; key_data = 8'hFF;
         @(posedge clk); #1;
         cnt++;
      end
      start = 1'b0; key_wr = 1'b0;
      chk({tag, "_busy"}, bad, 0);
      chk({tag, "_lat"}, cnt, INIT_LAT);
   endtask

   task automatic run_stream(input string tag, input logic [7:0] din[$], input logic [7:0] kv[$],
                             input int pr, output int cyc);
      logic [7:0] expq[$];
      int sent = 0, got = 0;
      bit prev_stall = 1'b0, push, pop;
      logic [7:0] prev_data = '0;
      cyc = 0;
      while (got < din.size() && cyc < 2000) begin
         if (prev_stall) chk({tag, "_hold"}, {out_valid, out_data}, {1'b1, prev_data});
         out_ready = ($urandom_range(99) < pr);
         in_valid  = (sent < din.size());
         in_data   = in_valid ? din[sent] : 8'h00;
         #1;
         push = in_valid && in_ready;
         pop  = out_valid && out_ready;
         if (pop) begin
            if (expq.size() > 0) chk(tag, out_data, expq.pop_front());
            else chk({tag, "_spurious"}, out_valid, 0);
            got++;
         end
         if (push) begin
            if (KV_OK && kv.size() > 0) begin
               expq.push_back(kv[sent]);
               void'(m_next());
            end else expq.push_back(din[sent] ^ m_next());
            sent++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk({tag, "_done"}, got, din.size());
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: sim time %0t exceeded budget", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] k_key[$], k_wiki[$], k_sec[$], k_rnd[$], none[$];
      logic [7:0] pt[$], ct1[$], pedia[$], ct2[$], atk[$], ct3[$], rnd[$];
      int cyc, len;
      k_key  = '{8'h4B, 8'h65, 8'h79};
      k_wiki = '{8'h57, 8'h69, 8'h6B, 8'h69};
      k_sec  = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
      pt     = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      ct1    = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      pedia  = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
      ct2    = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
      atk    = '{8'h41, 8'h74, 8'h74, 8'h61, 8'h63, 8'h6B, 8'h20, 8'h61, 8'h74, 8'h20,
                 8'h64, 8'h61, 8'h77, 8'h6E};
      ct3    = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38, 8'h35, 8'h52,
                 8'h54, 8'h4B, 8'h9B, 8'hF5};

      repeat (3) @(posedge clk);
      #1;
      chk("reset", {busy, init_done, out_valid, in_ready, out_data}, 12'h000);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_rdy", {in_ready, init_done}, 0);

      // known vector, full throughput
      load_key(k_key);
      do_start("t1", 3, -1);
      m_init(3);
      run_stream("t1", pt, ct1, 100, cyc);
      chk("t1_thru", cyc, 10);

      // second key, then a restart from READY with a pending output
      load_key(k_wiki);
      do_start("t2a", 4, -1);
      m_init(4);
      run_stream("t2a", pedia, ct2, 100, cyc);
      in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t2_pend", out_valid, 1);
      load_key(k_sec);
      do_start("t2b", 6, -1);
      m_init(6);
      run_stream("t2b", atk, ct3, 100, cyc);

      // decrypt with backpressure
      load_key(k_key);
      do_start("t3", 3, -1);
      m_init(3);
      run_stream("t3", ct1, pt, 50, cyc);

      // start/key_wr ignored while busy, then reset mid-KSA
      load_key(k_key);
      do_start("t4a", 3, 50);
      m_init(3);
      run_stream("t4a", pt, ct1, 100, cyc);
      start = 1'b1; key_len = 5'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t4_rst", {busy, init_done, out_valid, in_ready, out_data}, 12'h000);
      @(posedge clk); #1;
      rst = 1'b0;
      load_key(k_key);
      do_start("t4b", 3, -1);
      m_init(3);
      run_stream("t4b", pt, ct1, 70, cyc);

      // key_len 0 and key_len above KEY_MAX both mean a full-length key
      k_rnd = {};
      for (int n = 0; n < KEY_MAX; n++) k_rnd.push_back(8'($urandom));
      load_key(k_rnd);
      for (int pass = 0; pass < 2; pass++) begin
         rnd = {};
         for (int n = 0; n < 20; n++) rnd.push_back(8'($urandom));
         do_start(pass == 0 ? "t5z" : "t5s", pass == 0 ? 0 : 20, -1);
         m_init(KEY_MAX);
         run_stream(pass == 0 ? "t5z" : "t5s", rnd, none, 70, cyc);
      end

      // random keys, lengths and data
      for (int r = 0; r < 4; r++) begin
         len = (r == 0) ? 1 : int'($urandom_range(KEY_MAX, 1));
         k_rnd = {};
         rnd = {};
         for (int n = 0; n < len; n++) k_rnd.push_back(8'($urandom));
         for (int n = 0; n < 30; n++) rnd.push_back(8'($urandom));
         load_key(k_rnd);
         do_start("rnd", len, -1);
         m_init(len);
         run_stream("rnd", rnd, none, 60, cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
